// File: rtl/arm_array_multiplier.sv
// Unsigned 16x16 array multiplier: AND-gate partial products reduced by a
// carry-save adder array, final carry-propagate adder, registered 32-bit product.
module arm_array_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] P
);

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;

    // Row i holds sum bits at weight i+j and carry bits at weight i+j+1.
    logic [OP_W-1:0][OP_W-1:0] sum_row;
    logic [OP_W-1:0][OP_W-1:0] carry_row;
    logic [PROD_W-1:0]         prod_c;

    // Partial-product array reduced row by row in carry-save form.
    always_comb begin
        sum_row   = '0;
        carry_row = '0;
        prod_c    = '0;

        for (int j = 0; j < OP_W; j++) begin
            sum_row[0][j] = A[j] & B[0];
        end

        for (int i = 1; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                logic pp_bit;
                logic sum_in;
                logic carry_in;
                pp_bit   = A[j] & B[i];
                sum_in   = (j == OP_W - 1) ? 1'b0 : sum_row[i-1][j+1];
                carry_in = carry_row[i-1][j];
                sum_row[i][j]   = pp_bit ^ sum_in ^ carry_in;
                carry_row[i][j] = (pp_bit & sum_in) | (pp_bit & carry_in) | (sum_in & carry_in);
            end
        end

        for (int i = 0; i < OP_W; i++) begin
            prod_c[i] = sum_row[i][0];
        end

        // Carry-propagate merge of the last row; cannot overflow since A*B < 2^32.
        prod_c[PROD_W-1:OP_W] = {1'b0, sum_row[OP_W-1][OP_W-1:1]} + carry_row[OP_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            P <= '0;
        end else begin
            P <= prod_c;
        end
    end

endmodule

// File: tb/tb_arm_array_multiplier.sv
// Scoreboard bench for arm_array_multiplier: driver queues expected products,
// a negedge monitor pops and compares one entry per clock.
module tb_arm_array_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] P;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    arm_array_multiplier dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .P    (P)
    );

    always #5 clk = ~clk;

    // Apply one input set across one rising edge and record what P must become.
    task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input string tag);
        rst_n = r;
        A     = a;
        B     = b;
        @(posedge clk);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
    endtask

    // Reference model: plain unsigned arithmetic product, zero under reset.
    function automatic logic [31:0] model(input logic r, input logic [15:0] a, input logic [15:0] b);
        longint unsigned full;
        full = longint'(a) * longint'(b);
        return r ? full[31:0] : 32'h0;
    endfunction

    task automatic drive_model(input logic r, input logic [15:0] a, input logic [15:0] b,
                               input string tag);
        drive(r, a, b, model(r, a, b), tag);
    endtask

    // Operand generator biased toward corner values.
    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            4:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    // Monitor: P is valid every cycle after the first edge; compare at negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_tests++;
            if (P !== e) begin
                n_fail++;
                $display("FAIL %s: P=%h expected %h", t, P, e);
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        bit          drained;
        rst_n = 1'b0;
        A     = 16'h0;
        B     = 16'h0;

        drive(1'b0, 16'hFFFF, 16'hFFFF, 32'h00000000, "reset_edge0");
        drive(1'b0, 16'hFFFF, 16'hFFFF, 32'h00000000, "reset_edge1");
        drive(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max_after_reset");

        drive(1'b1, 16'h0000, 16'h1234, 32'h00000000, "zero_a");
        drive(1'b1, 16'h1234, 16'h0000, 32'h00000000, "zero_b");
        drive(1'b1, 16'h0001, 16'hABCD, 32'h0000ABCD, "one_a");
        drive(1'b1, 16'h8000, 16'h0002, 32'h00010000, "msb_times_two");
        drive(1'b1, 16'h8000, 16'h8000, 32'h40000000, "msb_squared");
        drive(1'b1, 16'h1234, 16'h5678, 32'h06260060, "typical");
        drive(1'b1, 16'h5678, 16'h1234, 32'h06260060, "typical_swapped");
        drive(1'b1, 16'hFFFF, 16'h0001, 32'h0000FFFF, "ffff_times_one");
        drive(1'b1, 16'hFFFF, 16'h0002, 32'h0001FFFE, "ffff_times_two");

        // Streaming with a single-edge reset in the middle.
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom());
            b = 16'($urandom());
            if (k == 20) begin
                drive(1'b0, a, b, 32'h00000000, "midstream_reset");
            end else begin
                drive_model(1'b1, a, b, "stream");
            end
        end

        // Corner-biased pairs, each also checked with operands swapped.
        for (int k = 0; k < 100; k++) begin
            a = pick();
            b = pick();
            drive_model(1'b1, a, b, "corner");
            drive_model(1'b1, b, a, "corner_swapped");
        end

        for (int k = 0; k < 10000; k++) begin
            drive_model(1'b1, 16'($urandom()), 16'($urandom()), "random");
        end

        // Let the monitor drain; bounded so the run always ends.
        drained = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
